// File: rtl/adder_n_pipe_pkg.sv
// Shared constants for the N-bit pipelined ripple-carry adder.
package adder_n_pipe_pkg;

  // Default operand/result width used when the parent does not override N.
  localparam int ADDER_DEFAULT_N = 32;

endpackage

// File: rtl/adder_n_pipe_full_adder.sv
// One-bit full adder cell built only from gate-level assigns.
// The N-bit adder is a chain of these cells.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  // Sum bit is the parity of the three inputs.
  assign s     = a ^ b ^ c_in;

  // Carry out is the majority of the three inputs.
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/adder_n_pipe.sv
// N-bit structural ripple-carry adder with carry and signed-overflow flags.
// The combinational result is usable directly (for example as a - b through
// a + ~b + 1). A one-cycle registered copy with a valid flag feeds
// pipelined datapaths.
module adder_n_pipe
  import adder_n_pipe_pkg::*;
#(
  parameter int N = ADDER_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic         valid_in,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow,
  output logic [N-1:0] sum_q,
  output logic         c_out_q,
  output logic         overflow_q,
  output logic         valid_q
);

  // carry[i] feeds cell i; carry[N] leaves the most significant cell.
  logic [N:0] carry;

  logic [N-1:0] sum_d;
  logic         c_out_d;
  logic         overflow_d;
  logic         valid_d;

  assign carry[0] = c_in;

  // Ripple chain of N full-adder cells, least significant bit first.
  for (genvar i = 0; i < N; i++) begin : g_cell
    full_adder_1b u_fa (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (carry[i]),
      .s     (sum[i]),
      .c_out (carry[i+1])
    );
  end

  // Unsigned carry out and two's-complement overflow. Overflow is set when
  // the carry into the sign bit differs from the carry out of it.
  assign c_out    = carry[N];
  assign overflow = carry[N] ^ carry[N-1];

  // Next-state values for the output registers. A qualified operation
  // captures the result. An idle cycle keeps the last result and drops valid.
  always_comb begin
    sum_d      = sum_q;
    c_out_d    = c_out_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    if (valid_in) begin
      sum_d      = sum;
      c_out_d    = c_out;
      overflow_d = overflow;
      valid_d    = 1'b1;
    end
  end

  // Output registers. Reset takes priority over a capture on the same edge,
  // so an in-flight result is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q      <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      c_out_q    <= c_out_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_adder_n_pipe.sv
// Self-checking bench for adder_n_pipe at N=32 and N=8. A plain-arithmetic
// reference model predicts both the combinational and registered outputs.
// Literal directed cases pin that model.
module tb_adder_n_pipe;

  logic clk = 1'b0;
  logic rst;

  logic [31:0] a32, b32, sum32, sum_q32;
  logic        cin32, vin32, co32, ov32, co_q32, ov_q32, v_q32;

  logic [7:0]  a8, b8, sum8, sum_q8;
  logic        cin8, vin8, co8, ov8, co_q8, ov_q8, v_q8;

  // Expected register state tracked by the model.
  logic [31:0] exp_sum_q32;
  logic        exp_co_q32, exp_ov_q32, exp_v_q32;
  logic [7:0]  exp_sum_q8;
  logic        exp_co_q8, exp_ov_q8, exp_v_q8;

  int compared   = 0;
  int mismatched = 0;

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // 32-bit instance of the adder.
  adder_n_pipe #(.N(32)) dut32 (
    .clk        (clk),
    .rst        (rst),
    .a          (a32),
    .b          (b32),
    .c_in       (cin32),
    .valid_in   (vin32),
    .sum        (sum32),
    .c_out      (co32),
    .overflow   (ov32),
    .sum_q      (sum_q32),
    .c_out_q    (co_q32),
    .overflow_q (ov_q32),
    .valid_q    (v_q32)
  );

  // 8-bit instance of the adder, sharing the reset.
  adder_n_pipe #(.N(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .a          (a8),
    .b          (b8),
    .c_in       (cin8),
    .valid_in   (vin8),
    .sum        (sum8),
    .c_out      (co8),
    .overflow   (ov8),
    .sum_q      (sum_q8),
    .c_out_q    (co_q8),
    .overflow_q (ov_q8),
    .valid_q    (v_q8)
  );

  // Reference model at N=32.
  // The unsigned result is computed at 33 bits.
  // Overflow is computed from the true signed sum.
  function automatic void model32(input logic [31:0] x, input logic [31:0] y,
                                  input logic ci, output logic [31:0] s,
                                  output logic co, output logic ov);
    logic [32:0] wide;
    longint      sx, sy, tot;
    wide = {1'b0, x} + {1'b0, y} + {32'b0, ci};
    s    = wide[31:0];
    co   = wide[32];
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    tot  = sx + sy + (ci ? 64'sd1 : 64'sd0);
    ov   = (tot > 64'sd2147483647) || (tot < -64'sd2147483648);
  endfunction

  // Reference model at N=8, using the same rules as model32.
  function automatic void model8(input logic [7:0] x, input logic [7:0] y,
                                 input logic ci, output logic [7:0] s,
                                 output logic co, output logic ov);
    logic [8:0] wide;
    int         tot;
    wide = {1'b0, x} + {1'b0, y} + {8'b0, ci};
    s    = wide[7:0];
    co   = wide[8];
    tot  = int'($signed(x)) + int'($signed(y)) + (ci ? 1 : 0);
    ov   = (tot > 127) || (tot < -128);
  endfunction

  // Single comparison point: counts every check and reports any miss.
  task automatic checkVal(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs to both instances on the falling edge.
  task automatic applyStimulus(input logic r,
                               input logic [31:0] xa, input logic [31:0] xb,
                               input logic xc, input logic xv,
                               input logic [7:0] ya, input logic [7:0] yb,
                               input logic yc, input logic yv);
    @(negedge clk);
    rst   = r;
    a32   = xa;
    b32   = xb;
    cin32 = xc;
    vin32 = xv;
    a8    = ya;
    b8    = yb;
    cin8  = yc;
    vin8  = yv;
    #1;
  endtask

  // Compare the combinational outputs against the model. Then advance
  // through the rising edge, update the register model, and compare the
  // registered outputs.
  task automatic checkOutput();
    logic [31:0] s32;
    logic [7:0]  s8;
    logic        c32, o32, c8, o8;
    model32(a32, b32, cin32, s32, c32, o32);
    model8(a8, b8, cin8, s8, c8, o8);
    checkVal("sum32", sum32, s32);
    checkVal("c_out32", {31'b0, co32}, {31'b0, c32});
    checkVal("overflow32", {31'b0, ov32}, {31'b0, o32});
    checkVal("sum8", {24'b0, sum8}, {24'b0, s8});
    checkVal("c_out8", {31'b0, co8}, {31'b0, c8});
    checkVal("overflow8", {31'b0, ov8}, {31'b0, o8});
    @(posedge clk);
    if (rst) begin
      exp_sum_q32 = '0; exp_co_q32 = 1'b0; exp_ov_q32 = 1'b0; exp_v_q32 = 1'b0;
      exp_sum_q8  = '0; exp_co_q8  = 1'b0; exp_ov_q8  = 1'b0; exp_v_q8  = 1'b0;
    end else begin
      exp_v_q32 = vin32;
      if (vin32) begin
        exp_sum_q32 = s32; exp_co_q32 = c32; exp_ov_q32 = o32;
      end
      exp_v_q8 = vin8;
      if (vin8) begin
        exp_sum_q8 = s8; exp_co_q8 = c8; exp_ov_q8 = o8;
      end
    end
    #1;
    checkVal("sum_q32", sum_q32, exp_sum_q32);
    checkVal("c_out_q32", {31'b0, co_q32}, {31'b0, exp_co_q32});
    checkVal("overflow_q32", {31'b0, ov_q32}, {31'b0, exp_ov_q32});
    checkVal("valid_q32", {31'b0, v_q32}, {31'b0, exp_v_q32});
    checkVal("sum_q8", {24'b0, sum_q8}, {24'b0, exp_sum_q8});
    checkVal("c_out_q8", {31'b0, co_q8}, {31'b0, exp_co_q8});
    checkVal("overflow_q8", {31'b0, ov_q8}, {31'b0, exp_ov_q8});
    checkVal("valid_q8", {31'b0, v_q8}, {31'b0, exp_v_q8});
  endtask

  // Directed cases with literal expectations, followed by randomized traffic.
  initial begin
    rst = 1'b1;
    a32 = '0; b32 = '0; cin32 = 1'b0; vin32 = 1'b0;
    a8  = '0; b8  = '0; cin8  = 1'b0; vin8  = 1'b0;

    // Reset state of the registers.
    applyStimulus(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    checkOutput();
    checkVal("reset_sum_q", sum_q32, 32'd0);
    checkVal("reset_valid_q", {31'b0, v_q32}, 32'd0);

    // 5 - 7 computed as 5 + ~7 + 1: negative result, so 5 < 7.
    applyStimulus(1'b0, 32'd5, ~32'd7, 1'b1, 1'b0, 8'd5, ~8'd7, 1'b1, 1'b0);
    checkVal("lt_sum", sum32, 32'hFFFF_FFFE);
    checkVal("lt_cout", {31'b0, co32}, 32'd0);
    checkVal("lt_ovf", {31'b0, ov32}, 32'd0);
    checkVal("lt_sign", {31'b0, sum32[31]}, 32'd1);
    checkVal("lt_sum8", {24'b0, sum8}, 32'h0000_00FE);
    checkOutput();

    // Largest positive value + 1 overflows into the sign bit.
    applyStimulus(1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0,
                  8'h7F, 8'h01, 1'b0, 1'b0);
    checkVal("maxpos_sum", sum32, 32'h8000_0000);
    checkVal("maxpos_cout", {31'b0, co32}, 32'd0);
    checkVal("maxpos_ovf", {31'b0, ov32}, 32'd1);
    checkVal("maxpos_ovf8", {31'b0, ov8}, 32'd1);
    checkOutput();

    // Most negative + most negative: zero result with carry and overflow.
    applyStimulus(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
                  8'h80, 8'h80, 1'b0, 1'b0);
    checkVal("minneg_sum", sum32, 32'd0);
    checkVal("minneg_cout", {31'b0, co32}, 32'd1);
    checkVal("minneg_ovf", {31'b0, ov32}, 32'd1);
    checkVal("minneg_sum8", {24'b0, sum8}, 32'd0);
    checkVal("minneg_cout8", {31'b0, co8}, 32'd1);
    checkOutput();

    // All-ones + 0 + carry-in wraps to zero without signed overflow.
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0,
                  8'hFF, 8'h00, 1'b1, 1'b0);
    checkVal("wrap_sum", sum32, 32'd0);
    checkVal("wrap_cout", {31'b0, co32}, 32'd1);
    checkVal("wrap_ovf", {31'b0, ov32}, 32'd0);
    checkOutput();

    // Registered path: capture 3 + 4, then hold through an idle cycle.
    applyStimulus(1'b0, 32'd3, 32'd4, 1'b0, 1'b1, 8'd3, 8'd4, 1'b0, 1'b1);
    checkOutput();
    checkVal("cap_sum_q", sum_q32, 32'd7);
    checkVal("cap_valid_q", {31'b0, v_q32}, 32'd1);
    applyStimulus(1'b0, 32'd100, 32'd200, 1'b0, 1'b0,
                  8'd10, 8'd20, 1'b0, 1'b0);
    checkOutput();
    checkVal("hold_sum_q", sum_q32, 32'd7);
    checkVal("hold_valid_q", {31'b0, v_q32}, 32'd0);
    checkVal("hold_sum_q8", {24'b0, sum_q8}, 32'd7);

    // Reset wins over a capture, while the combinational path keeps working.
    applyStimulus(1'b0, 32'd9, 32'd9, 1'b1, 1'b1, 8'd9, 8'd9, 1'b1, 1'b1);
    checkOutput();
    applyStimulus(1'b1, 32'd20, 32'd22, 1'b0, 1'b1, 8'd1, 8'd1, 1'b0, 1'b1);
    checkVal("rst_comb_sum", sum32, 32'd42);
    checkOutput();
    checkVal("rst_sum_q", sum_q32, 32'd0);
    checkVal("rst_valid_q", {31'b0, v_q32}, 32'd0);

    // Randomized traffic with occasional resets and idle cycles.
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    $urandom(), $urandom(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    8'($urandom()), 8'($urandom()), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      checkOutput();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
